// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Buffered 8N1 UART receiver. The asynchronous RX line is
//               synchronised, frames are deserialised LSB first, the stop
//               bit is checked, and good bytes are queued in a small
//               first-word-fall-through FIFO that downstream logic drains
//               with i_RD_EN. Framing errors and overruns are reported as
//               one-cycle registered pulses.
// Ports       : CLK          - single rising-edge clock
//               RST_N        - synchronous active-low reset
//               RX           - asynchronous serial input, idle high
//               i_RD_EN      - pop the head byte (ignored while empty)
//               o_RX_Byte    - head of FIFO, 8'h00 while empty
//               o_RX_Empty   - FIFO holds no bytes
//               o_RX_Full    - FIFO holds FIFO_DEPTH bytes
//               o_Frame_Err  - pulse: stop bit sampled low
//               o_Overrun    - pulse: good byte dropped, FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  input  logic       i_RD_EN,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Empty,
  output logic       o_RX_Full,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; both flops reset to the idle (high) line level so
  // that reset never looks like a start bit.
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive state machine
  // --------------------------------------------------------------------------
  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             frame_err;
  logic             overrun;

  // FIFO bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic empty;
  logic full;
  logic pop;
  logic stop_sample;
  logic push;
  logic drop;

  assign empty       = (count == '0);
  assign full        = (count == COUNT_FULL);
  assign pop         = i_RD_EN && !empty;
  assign stop_sample = (state == S_STOP) && (clk_cnt == BIT_LAST);
  // A full FIFO still accepts the byte when a pop frees a slot in the same cycle.
  assign push        = stop_sample && rx_s && (!full || pop);
  assign drop        = stop_sample && rx_s && full && !pop;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Holding the counter at zero here clears it on entry to START.
          clk_cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            // A line already back high at mid start bit is a glitch.
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              overrun <= drop;
              state   <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // Stay here while the line is held low so a break is not
          // mistaken for a new start bit.
          clk_cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          clk_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset; the count alone defines validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  assign o_RX_Byte   = empty ? 8'h00 : mem[rd_ptr];
  assign o_RX_Empty  = empty;
  assign o_RX_Full   = full;
  assign o_Frame_Err = frame_err;
  assign o_Overrun   = overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A table of single
//               frames is replayed in a loop, followed by hand-written
//               sequences for exact push timing, overrun, framing error with
//               a held break, glitch rejection, push/pop on a full FIFO and
//               reset in the middle of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB   = 217;
  localparam int DEPTH = 4;
  // Cycles from the first posedge after RX falls to the stop-sample edge:
  // 2 synchroniser + 1 IDLE detect + HALF + 9*CPB.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       RX;
  logic       i_RD_EN;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Empty;
  logic       o_RX_Full;
  logic       o_Frame_Err;
  logic       o_Overrun;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RX         (RX),
    .i_RD_EN    (i_RD_EN),
    .o_RX_Byte  (o_RX_Byte),
    .o_RX_Empty (o_RX_Empty),
    .o_RX_Full  (o_RX_Full),
    .o_Frame_Err(o_Frame_Err),
    .o_Overrun  (o_Overrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  // Counting high cycles makes a two-cycle pulse show up as 2.
  always @(negedge CLK) begin
    if (o_Frame_Err === 1'b1) ferr_cnt++;
    if (o_Overrun === 1'b1)   ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All drive tasks start and end one time unit after a rising edge.
  task automatic drive_bit(input logic v);
    RX = v;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * CPB) @(posedge CLK);
    #1;
  endtask

  task automatic pop_one();
    @(posedge CLK);
    #1 i_RD_EN = 1'b1;
    @(posedge CLK);
    #1 i_RD_EN = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [7:0] exp);
    @(negedge CLK);
    check({name, "_nonempty"}, {31'd0, o_RX_Empty}, 32'd0);
    check({name, "_byte"}, {24'd0, o_RX_Byte}, {24'd0, exp});
    pop_one();
  endtask

  task automatic expect_empty(input string name);
    @(negedge CLK);
    check({name, "_empty"}, {31'd0, o_RX_Empty}, 32'd1);
    check({name, "_byte0"}, {24'd0, o_RX_Byte}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_ferr;
    logic       exp_empty;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];
  int   f0, o0;

  initial begin
    vecs[0] = '{data: 8'h00, stop: 1'b1, exp_ferr: 0, exp_empty: 1'b0, exp_byte: 8'h00};
    vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_ferr: 0, exp_empty: 1'b0, exp_byte: 8'hFF};
    vecs[2] = '{data: 8'h81, stop: 1'b1, exp_ferr: 0, exp_empty: 1'b0, exp_byte: 8'h81};
    vecs[3] = '{data: 8'h55, stop: 1'b0, exp_ferr: 1, exp_empty: 1'b1, exp_byte: 8'h00};
    vecs[4] = '{data: 8'h96, stop: 1'b1, exp_ferr: 0, exp_empty: 1'b0, exp_byte: 8'h96};

    RST_N   = 1'b0;
    RX      = 1'b1;
    i_RD_EN = 1'b0;

    // ---------------- reset values ----------------
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_empty", {31'd0, o_RX_Empty}, 32'd1);
    check("rst_full", {31'd0, o_RX_Full}, 32'd0);
    check("rst_byte", {24'd0, o_RX_Byte}, 32'd0);
    check("rst_ferr", {31'd0, o_Frame_Err}, 32'd0);
    check("rst_ovr", {31'd0, o_Overrun}, 32'd0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    idle_bits(1);

    // ---------------- single byte with exact push timing ----------------
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'h3A, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge CLK);
        @(negedge CLK);
        check("single_empty_before", {31'd0, o_RX_Empty}, 32'd1);
        @(negedge CLK);
        check("single_empty_after", {31'd0, o_RX_Empty}, 32'd0);
        check("single_byte", {24'd0, o_RX_Byte}, 32'h3A);
      end
    join
    idle_bits(2);
    check("single_no_ferr", ferr_cnt - f0, 0);
    check("single_no_ovr", ovr_cnt - o0, 0);
    check("single_still_3a", {24'd0, o_RX_Byte}, 32'h3A);
    pop_one();
    expect_empty("single_pop");

    // ---------------- table of frames ----------------
    for (int v = 0; v < 5; v++) begin
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      idle_bits(2);
      @(negedge CLK);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
      check($sformatf("vec%0d_empty", v), {31'd0, o_RX_Empty}, {31'd0, vecs[v].exp_empty});
      check($sformatf("vec%0d_byte", v), {24'd0, o_RX_Byte}, {24'd0, vecs[v].exp_byte});
      if (!vecs[v].exp_empty) pop_one();
    end

    // ---------------- overrun ----------------
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1);
      if (b == 4) begin
        check("ovr_full_after4", {31'd0, o_RX_Full}, 32'd1);
        check("ovr_none_after4", ovr_cnt - o0, 0);
      end
    end
    idle_bits(2);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_no_ferr", ferr_cnt - f0, 0);
    check("ovr_full", {31'd0, o_RX_Full}, 32'd1);
    read_expect("ovr_rd1", 8'h01);
    read_expect("ovr_rd2", 8'h02);
    read_expect("ovr_rd3", 8'h03);
    read_expect("ovr_rd4", 8'h04);
    expect_empty("ovr_drained");

    // ---------------- framing error with held break ----------------
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b0);
    RX = 1'b0;
    repeat (3 * CPB) @(posedge CLK);
    #1;
    idle_bits(2);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_ovr", ovr_cnt - o0, 0);
    expect_empty("ferr_nopush");
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    check("ferr_single_pulse", ferr_cnt - f0, 1);
    read_expect("ferr_next", 8'h5A);
    expect_empty("ferr_drained");

    // ---------------- glitch rejection ----------------
    f0 = ferr_cnt; o0 = ovr_cnt;
    RX = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    idle_bits(2);
    expect_empty("glitch_nopush");
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_no_ovr", ovr_cnt - o0, 0);
    send_frame(8'hC3, 1'b1);
    idle_bits(1);
    read_expect("glitch_next", 8'hC3);
    expect_empty("glitch_drained");

    // ---------------- push and pop together on a full FIFO ----------------
    o0 = ovr_cnt;
    send_frame(8'h10, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h13, 1'b1);
    idle_bits(2);
    check("simul_full_before", {31'd0, o_RX_Full}, 32'd1);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge CLK);
        #1 i_RD_EN = 1'b1;
        @(posedge CLK);
        #1 i_RD_EN = 1'b0;
        @(negedge CLK);
        check("simul_full_after", {31'd0, o_RX_Full}, 32'd1);
        check("simul_no_ovr_pulse", {31'd0, o_Overrun}, 32'd0);
      end
    join
    idle_bits(1);
    check("simul_ovr_count", ovr_cnt - o0, 0);
    read_expect("simul_rd1", 8'h11);
    read_expect("simul_rd2", 8'h12);
    read_expect("simul_rd3", 8'h13);
    read_expect("simul_rd4", 8'h77);
    expect_empty("simul_drained");

    // ---------------- reset in the middle of a frame ----------------
    send_frame(8'h99, 1'b1);
    idle_bits(1);
    @(negedge CLK);
    check("midrst_prefill", {31'd0, o_RX_Empty}, 32'd0);
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        // Middle of data bit 4 (bit slots start at 1*CPB after start bit).
        repeat (5 * CPB + CPB / 2) @(posedge CLK);
        #1 RST_N = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_empty", {31'd0, o_RX_Empty}, 32'd1);
        check("midrst_full", {31'd0, o_RX_Full}, 32'd0);
        check("midrst_byte", {24'd0, o_RX_Byte}, 32'd0);
        check("midrst_ferr", {31'd0, o_Frame_Err}, 32'd0);
        check("midrst_ovr", {31'd0, o_Overrun}, 32'd0);
      end
    join
    idle_bits(2);
    expect_empty("midrst_nopush");
    check("midrst_no_ferr", ferr_cnt - f0, 0);
    check("midrst_no_ovr", ovr_cnt - o0, 0);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    read_expect("midrst_next", 8'h3C);
    expect_empty("midrst_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
